// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multiply/divide unit for the EX stage. Accepts MULT, MULTU,
//               DIV, DIVU, MTHI and MTLO, runs multi-cycle operations behind
//               a busy flag and holds the architectural HI/LO registers.
//               Optional macro MD_MADD_EN adds MADD/MADDU (op 110/111),
//               which accumulate a product into {HI,LO}.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_div   = 3'b010;
    localparam logic [2:0] c_op_divu  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;
`ifdef MD_MADD_EN
    localparam logic [2:0] c_op_madd  = 3'b110;
    localparam logic [2:0] c_op_maddu = 3'b111;
`endif

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [63:0] r_res;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_launch;
    logic [3:0]  w_launch_cnt;
    logic [63:0] w_launch_res;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_done;

    // Even op codes (MULT, DIV, MADD) are the signed variants
    logic        w_sgn;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
`ifdef MD_MADD_EN
    logic [63:0] w_acc;
`endif

    assign w_accept = (r_state == c_st_idle) && start;
    assign w_sgn    = ~op[0];

    // Shared arithmetic: one 64-bit multiplier on sign/zero-extended operands,
    // one unsigned divider on magnitudes with sign fix-up afterwards
    always_comb begin
        w_ma   = {{32{w_sgn & a[31]}}, a};
        w_mb   = {{32{w_sgn & b[31]}}, b};
        w_prod = w_ma * w_mb;
        w_dvd  = (w_sgn && a[31]) ? (32'd0 - a) : a;
        w_dvs  = (w_sgn && b[31]) ? (32'd0 - b) : b;
        w_uq   = w_dvd / w_dvs;
        w_ur   = w_dvd % w_dvs;
        w_q    = (w_sgn && (a[31] ^ b[31])) ? (32'd0 - w_uq) : w_uq;
        w_r    = (w_sgn && a[31]) ? (32'd0 - w_ur) : w_ur;
`ifdef MD_MADD_EN
        w_acc  = {r_hi, r_lo} + w_prod;
`endif
    end

    // Request decode: what an accepted request launches or writes directly.
    // Divide by zero launches with the current {HI,LO} so completion is a no-op.
    always_comb begin
        w_launch     = 1'b0;
        w_launch_cnt = c_mult_cnt;
        w_launch_res = w_prod;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        if (w_accept) begin
            case (op)
                c_op_mult, c_op_multu: begin
                    w_launch     = 1'b1;
                    w_launch_cnt = c_mult_cnt;
                    w_launch_res = w_prod;
                end
                c_op_div, c_op_divu: begin
                    w_launch     = 1'b1;
                    w_launch_cnt = c_div_cnt;
                    w_launch_res = (b == 32'd0) ? {r_hi, r_lo} : {w_r, w_q};
                end
                c_op_mthi: w_mthi = 1'b1;
                c_op_mtlo: w_mtlo = 1'b1;
`ifdef MD_MADD_EN
                c_op_madd, c_op_maddu: begin
                    w_launch     = 1'b1;
                    w_launch_cnt = c_mult_cnt;
                    w_launch_res = w_acc;
                end
`endif
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: launch moves to RUN, the last counted cycle returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_launch) w_state_nxt = c_st_run;
            c_st_run:  if (r_cnt == 4'd1) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs of the state machine: busy flag and completion strobe
    always_comb begin
        busy   = (r_state == c_st_run);
        w_done = (r_state == c_st_run) && (r_cnt == 4'd1);
    end

    // Counter, pending result and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
            r_res <= 64'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_launch) begin
                r_cnt <= w_launch_cnt;
                r_res <= w_launch_res;
            end else if (r_state == c_st_run) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
            if (w_done) begin
                r_hi <= r_res[63:32];
                r_lo <= r_res[31:0];
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit. A transaction-level model
//               tracks HI/LO and the remaining busy time; outputs are compared
//               every cycle, with literal expectations for directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    // Model state
    bit [31:0] m_hi;
    bit [31:0] m_lo;
    int        m_left;
    bit        m_wr;
    bit [63:0] m_pend;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0; m_pend = 0;
    endtask

    // Effect of one rising edge on the architectural state
    task automatic model_edge();
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!reset_n) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) {m_hi, m_lo} = m_pend;
        end else if (start) begin
            case (op)
                3'd0: begin m_pend = 64'(sa * sb); m_wr = 1; m_left = MC; end
                3'd1: begin m_pend = 64'(ua * ub); m_wr = 1; m_left = MC; end
                3'd2: begin
                    m_left = DC;
                    m_wr   = (b != 0);
                    if (b != 0) begin
                        q = sa / sb; r = sa % sb;
                        m_pend = {r[31:0], q[31:0]};
                    end
                end
                3'd3: begin
                    m_left = DC;
                    m_wr   = (b != 0);
                    if (b != 0) m_pend = {32'(ua % ub), 32'(ua / ub)};
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
`ifdef MD_MADD_EN
                3'd6: begin m_pend = {m_hi, m_lo} + 64'(sa * sb); m_wr = 1; m_left = MC; end
                3'd7: begin m_pend = {m_hi, m_lo} + 64'(ua * ub); m_wr = 1; m_left = MC; end
`endif
                default: ;
            endcase
        end
    endtask

    task automatic check();
        cmp("busy", 32'(busy), 32'(m_left > 0));
        cmp("hi", hi, m_hi);
        cmp("lo", lo, m_lo);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check();
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        reset_n = 1'b0;
        tick(); tick();
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_hi", hi, 32'd0);
        cmp("rst_lo", lo, 32'd0);
        reset_n = 1'b1;
        tick();

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        cmp("mult_busy_e0", 32'(busy), 32'd1);
        idle(MC - 1);
        cmp("mult_busy_last", 32'(busy), 32'd1);
        tick();
        cmp("mult_busy_done", 32'(busy), 32'd0);
        cmp("mult_hi", hi, 32'hFFFF_FFFF);
        cmp("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2 and DIVU 7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(DC - 1);
        cmp("div_busy_last", 32'(busy), 32'd1);
        tick();
        cmp("div_lo", lo, 32'hFFFF_FFFD);
        cmp("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd2);
        idle(DC);
        cmp("divu_lo", lo, 32'd3);
        cmp("divu_hi", hi, 32'd1);

        // Signed overflow case
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        cmp("divovf_lo", lo, 32'h8000_0000);
        cmp("divovf_hi", hi, 32'd0);

        // MTHI / MTLO then divide by zero
        issue(3'd4, 32'h1234_5678, 32'd0);
        cmp("mthi_hi", hi, 32'h1234_5678);
        cmp("mthi_busy", 32'(busy), 32'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);
        cmp("mtlo_lo", lo, 32'h9ABC_DEF0);
        issue(3'd3, 32'd5, 32'd0);
        idle(DC - 1);
        cmp("dz_busy", 32'(busy), 32'd1);
        tick();
        cmp("dz_hi", hi, 32'h1234_5678);
        cmp("dz_lo", lo, 32'h9ABC_DEF0);

        // MULTU with start held and MTHI during busy
        op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        op = 3'd4; a = 32'hDEAD_BEEF;
        repeat (MC) tick();
        start = 1'b0;
        cmp("multu_hi", hi, 32'hFFFF_FFFE);
        cmp("multu_lo", lo, 32'h0000_0001);

        // Reset in the middle of a DIV
        issue(3'd2, 32'd100, 32'd7);
        idle(3);
        reset_n = 1'b0;
        #1;
        model_reset();
        cmp("midrst_busy", 32'(busy), 32'd0);
        cmp("midrst_hi", hi, 32'd0);
        cmp("midrst_lo", lo, 32'd0);
        tick();
        reset_n = 1'b1;
        idle(DC + 2);
        cmp("postrst_hi", hi, 32'd0);
        cmp("postrst_lo", lo, 32'd0);

`ifdef MD_MADD_EN
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'd3, 32'd4);
        cmp("madd_busy", 32'(busy), 32'd1);
        idle(MC);
        cmp("madd_hi", hi, 32'd0);
        cmp("madd_lo", lo, 32'd17);
`else
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'd3, 32'd4);
        cmp("op6_busy", 32'(busy), 32'd0);
        idle(2);
        cmp("op6_hi", hi, 32'd0);
        cmp("op6_lo", lo, 32'd5);
`endif

        // Randomized traffic, including requests while busy and resets
        for (int i = 0; i < 2500; i++) begin
            start   = ($urandom_range(0, 2) == 0);
            op      = 3'($urandom_range(0, 7));
            a       = pick();
            b       = pick();
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
